// File: rtl/uart_rx_ctrl.sv
// Receive-side UART controller: start-bit detect, mid-bit shift strobes, framing check, valid/ack handoff.
// Optional build macro RX_SYNC_EN adds a 2-flop synchroniser between the rx pin and all line decisions.
module uart_rx_ctrl #(
  parameter int BAUD_DIV = 434,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       sdi,
  output logic       sh,
  input  logic [9:0] frame,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int            CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);
  localparam logic [3:0]    LAST_BIT  = 4'd9;

  typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] baud_cnt, baud_cnt_nxt;
  logic [3:0]    bit_cnt, bit_cnt_nxt;
  logic          rx_s;

`ifdef RX_SYNC_EN
  logic [1:0] rx_sync;

  // Reset to idle-high so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) rx_sync <= 2'b11;
    else       rx_sync <= {rx_sync[0], rx};
  end
  assign rx_s = rx_sync[1];
`else
  assign rx_s = rx;
`endif

  assign sdi  = rx_s;
  assign busy = (state != IDLE);

  // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_cnt_nxt  = bit_cnt;
    sh           = 1'b0;
    case (state)
      IDLE: begin
        bit_cnt_nxt = '0;
        if (!rx_s) begin
          state_nxt    = START;
          baud_cnt_nxt = '0;
        end
      end
      START: begin
        if (baud_cnt == HALF_LAST) begin
          baud_cnt_nxt = '0;
          if (!rx_s) begin
            sh          = 1'b1;
            bit_cnt_nxt = 4'd1;
            state_nxt   = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          baud_cnt_nxt = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          sh           = 1'b1;
          baud_cnt_nxt = '0;
          bit_cnt_nxt  = bit_cnt + 4'd1;
          // The pulse that brings the count to ten is the stop-bit sample.
          if (bit_cnt == LAST_BIT) state_nxt = DONE;
        end else begin
          baud_cnt_nxt = baud_cnt + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      if (state == DONE) begin
        // A fresh byte beats a same-cycle ack; only an unacknowledged old byte counts as overrun.
        rx_data   <= frame[8:1];
        frame_err <= frame[0] | ~frame[9];
        rx_valid  <= 1'b1;
        if (rx_valid && !rx_ack) overrun <= 1'b1;
      end else if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: a cycle-timeline reference model checked every cycle,
// plus directed frames with hand-computed literal expectations.
module tb_uart_rx_ctrl;

  localparam int BAUD = 16;
  localparam int HALF = BAUD / 2;
  localparam int FRAME_LEN = 10 * BAUD;
  localparam int DONE_OFF = HALF + 9 * BAUD + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic       sdi, sh, rx_valid, frame_err, overrun, busy;
  logic [7:0] rx_data;
  logic [9:0] frame = '0;

  int n_cmp = 0;
  int n_err = 0;
  int sh_cnt = 0;
  int cyc = 0;

  uart_rx_ctrl #(.BAUD_DIV(BAUD)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .sdi       (sdi),
    .sh        (sh),
    .frame     (frame),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // External 10-bit receive shift register: sdi enters bit 9, LSB-first.
  always @(posedge clk) if (sh === 1'b1) frame <= {sdi, frame[9:1]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a frame is a timeline anchored at the cycle the line is first seen low.
  // Samples fall at HALF + k*BAUD (k = 0..9), delivery happens one cycle after the last sample.
  bit         m_active = 1'b0;
  int         m_start = 0;
  logic [9:0] m_bits = '0;
  logic [7:0] m_data = '0;
  logic       m_valid = 1'b0, m_err = 1'b0, m_ovr = 1'b0;
  logic [1:0] rx_hist = 2'b11;

  always @(negedge clk) begin
    logic line_v, exp_sh, deliver, abort_start, was_active;
    int   off, k;
`ifdef RX_SYNC_EN
    line_v = rx_hist[1];
`else
    line_v = rx;
`endif
    if (reset) begin
      m_active = 1'b0;
      m_data   = '0;
      m_valid  = 1'b0;
      m_err    = 1'b0;
      m_ovr    = 1'b0;
      rx_hist  = 2'b11;
    end else begin
      exp_sh      = 1'b0;
      deliver     = 1'b0;
      abort_start = 1'b0;
      was_active  = m_active;
      if (m_active) begin
        off = cyc - m_start;
        if (off >= HALF && (off - HALF) % BAUD == 0 && (off - HALF) / BAUD <= 9) begin
          k = (off - HALF) / BAUD;
          if (k == 0 && line_v) abort_start = 1'b1;
          else begin
            exp_sh    = 1'b1;
            m_bits[k] = line_v;
          end
        end
        if (off == DONE_OFF) deliver = 1'b1;
      end
      check($sformatf("sh c%0d", cyc), 32'(sh), 32'(exp_sh));
      check($sformatf("busy c%0d", cyc), 32'(busy), 32'(was_active));
      check($sformatf("sdi c%0d", cyc), 32'(sdi), 32'(line_v));
      check($sformatf("rx_data c%0d", cyc), 32'(rx_data), 32'(m_data));
      check($sformatf("rx_valid c%0d", cyc), 32'(rx_valid), 32'(m_valid));
      check($sformatf("frame_err c%0d", cyc), 32'(frame_err), 32'(m_err));
      check($sformatf("overrun c%0d", cyc), 32'(overrun), 32'(m_ovr));
      if (sh === 1'b1) sh_cnt++;
      if (deliver) begin
        if (m_valid && !rx_ack) m_ovr = 1'b1;
        m_data   = m_bits[8:1];
        m_err    = m_bits[0] | ~m_bits[9];
        m_valid  = 1'b1;
        m_active = 1'b0;
      end else if (rx_ack && m_valid) begin
        m_valid = 1'b0;
      end
      if (abort_start) m_active = 1'b0;
      else if (!was_active && !line_v) begin
        m_active = 1'b1;
        m_start  = cyc;
      end
      rx_hist = {rx_hist[0], rx};
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  // Drives one 8N1 frame cycle by cycle; ack_off pulses rx_ack at that offset, limit truncates.
  task automatic send(input logic [7:0] d, input logic stop, input int ack_off, input int limit);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int off = 0; off < limit && off < FRAME_LEN; off++) begin
      rx     = f[off / BAUD];
      rx_ack = (off == ack_off);
      tick();
    end
    rx     = 1'b1;
    rx_ack = 1'b0;
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);

    s0 = sh_cnt;
    send(8'hA5, 1'b1, -1, FRAME_LEN);
    idle(10);
    check("A5 sh count", 32'(sh_cnt - s0), 32'd10);
    check("A5 rx_data", 32'(rx_data), 32'hA5);
    check("A5 rx_valid", 32'(rx_valid), 32'd1);
    check("A5 frame_err", 32'(frame_err), 32'd0);
    ack_pulse();
    check("A5 ack clears", 32'(rx_valid), 32'd0);

    s0 = sh_cnt;
    rx = 1'b0;
    repeat (4) tick();
    idle(12);
    check("glitch sh count", 32'(sh_cnt - s0), 32'd0);
    check("glitch busy", 32'(busy), 32'd0);
    check("glitch rx_valid", 32'(rx_valid), 32'd0);

    s0 = sh_cnt;
    send(8'h3C, 1'b0, -1, FRAME_LEN);
    idle(20);
    check("3C sh count", 32'(sh_cnt - s0), 32'd10);
    check("3C rx_data", 32'(rx_data), 32'h3C);
    check("3C frame_err", 32'(frame_err), 32'd1);
    check("3C rx_valid", 32'(rx_valid), 32'd1);
    ack_pulse();

    send(8'h11, 1'b1, -1, FRAME_LEN);
    idle(4);
    send(8'h22, 1'b1, -1, FRAME_LEN);
    idle(10);
    check("22 rx_data", 32'(rx_data), 32'h22);
    check("22 overrun", 32'(overrun), 32'd1);
    check("22 rx_valid", 32'(rx_valid), 32'd1);
    ack_pulse();
    check("22 ack clears", 32'(rx_valid), 32'd0);
    check("overrun sticky", 32'(overrun), 32'd1);

    do_reset();
    check("reset clears overrun", 32'(overrun), 32'd0);
    send(8'h5A, 1'b1, -1, FRAME_LEN);
    idle(4);
    send(8'h96, 1'b1, DONE_OFF, FRAME_LEN);
    idle(5);
    check("ack@done rx_valid", 32'(rx_valid), 32'd1);
    check("ack@done rx_data", 32'(rx_data), 32'h96);
    check("ack@done overrun", 32'(overrun), 32'd0);

    s0 = sh_cnt;
    send(8'hFF, 1'b1, -1, HALF + 4 * BAUD + 4);
    check("FF partial sh count", 32'(sh_cnt - s0), 32'd5);
    check("FF busy mid-frame", 32'(busy), 32'd1);
    do_reset();
    check("abort rx_valid", 32'(rx_valid), 32'd0);
    check("abort rx_data", 32'(rx_data), 32'd0);
    check("abort frame_err", 32'(frame_err), 32'd0);
    check("abort overrun", 32'(overrun), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort sh", 32'(sh), 32'd0);
    idle(5);
    s0 = sh_cnt;
    send(8'h81, 1'b1, -1, FRAME_LEN);
    idle(10);
    check("81 sh count", 32'(sh_cnt - s0), 32'd10);
    check("81 rx_data", 32'(rx_data), 32'h81);
    check("81 frame_err", 32'(frame_err), 32'd0);
    check("81 rx_valid", 32'(rx_valid), 32'd1);
    check("81 overrun", 32'(overrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
